// File: rtl/pmem_arbiter_if.sv
// Shared memory-port bundle: instruction and data requesters plus the
// physical memory side, as seen by the arbiter (slave) and its users (master).
interface pmem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
);
  logic              i_read;
  logic [ADDR_W-1:0] i_address;
  logic              i_resp;
  logic [LINE_W-1:0] i_rdata;
  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_address;
  logic [LINE_W-1:0] d_wdata;
  logic              d_resp;
  logic [LINE_W-1:0] d_rdata;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic              pmem_resp;
  logic [LINE_W-1:0] pmem_rdata;

  modport slave (
    input  i_read, i_address,
    output i_resp, i_rdata,
    input  d_read, d_write, d_address, d_wdata,
    output d_resp, d_rdata,
    output pmem_read, pmem_write,
    output pmem_address, pmem_wdata,
    input  pmem_resp, pmem_rdata
  );

  modport master (
    output i_read, i_address,
    input  i_resp, i_rdata,
    output d_read, d_write, d_address, d_wdata,
    input  d_resp, d_rdata,
    input  pmem_read, pmem_write,
    input  pmem_address, pmem_wdata,
    output pmem_resp, pmem_rdata
  );
endinterface

// File: rtl/pmem_arbiter.sv
// Round-robin arbiter sharing one physical memory port between the
// instruction-side and data-side caches; grant held until pmem_resp.
module pmem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input logic            clk,
  input logic            rst_n,
  pmem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D
  } state_t;

  state_t state_q, state_d;
  logic   last_q, last_d;

  logic              req_i, req_d;
  logic              grant_i, grant_d;
  logic              mem_rd, mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic              i_resp, d_resp;
  logic [LINE_W-1:0] i_rdata, d_rdata;

  assign req_i   = bus.i_read;
  assign req_d   = bus.d_read | bus.d_write;
  // last_q = 1 means D went last, so I wins a tie
  assign grant_i = req_i & (~req_d | last_q);
  assign grant_d = req_d & ~grant_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    i_resp    = 1'b0;
    i_rdata   = '0;
    d_resp    = 1'b0;
    d_rdata   = '0;
    unique case (state_q)
      IDLE: begin
        unique case (1'b1)
          grant_i: begin
            state_d = SERVE_I;
            last_d  = 1'b0;
          end
          grant_d: begin
            state_d = SERVE_D;
            last_d  = 1'b1;
          end
          default: state_d = IDLE;
        endcase
      end
      SERVE_I: begin
        mem_rd   = bus.i_read;
        mem_addr = bus.i_address;
        i_resp   = bus.pmem_resp;
        i_rdata  = bus.pmem_rdata;
        if (bus.pmem_resp) state_d = IDLE;
      end
      SERVE_D: begin
        mem_rd    = bus.d_read;
        mem_wr    = bus.d_write;
        mem_addr  = bus.d_address;
        mem_wdata = bus.d_wdata;
        d_resp    = bus.pmem_resp;
        d_rdata   = bus.pmem_rdata;
        if (bus.pmem_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.pmem_read    = mem_rd;
  assign bus.pmem_write   = mem_wr;
  assign bus.pmem_address = mem_addr;
  assign bus.pmem_wdata   = mem_wdata;
  assign bus.i_resp       = i_resp;
  assign bus.i_rdata      = i_rdata;
  assign bus.d_resp       = d_resp;
  assign bus.d_rdata      = d_rdata;

endmodule
